seven_seg_display_ctrl: RTL and testbench

Display controller for the 4-digit common-anode seven-segment bank. It time-multiplexes four digits and inserts an anti-ghosting guard interval at every digit change. It also applies PWM brightness, leading-zero suppression, per-digit blink, and a double-buffered update handshake. The block sits between the clock/counter logic, which writes through the update port, and the FPGA display pins, and it drives both anodes and cathodes.

---
 rtl/seven_seg_display_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_seven_seg_display_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_display_ctrl.sv
// Four-digit common-anode seven-segment scan controller with anti-ghosting
// guard, per-frame PWM brightness, leading-zero suppression, per-digit blink
// and a double-buffered (shadow/active) update handshake.
module seven_seg_display_ctrl #(
    parameter int unsigned SLOT_LEN     = 16,
    parameter int unsigned BLANK_LEN    = 1,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic        base_scan_clock,
    input  logic        RESETn,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [15:0] upd_data,
    input  logic [3:0]  upd_dp,
    input  logic [3:0]  brightness,
    input  logic        lzs_en,
    input  logic [3:0]  blink_mask,
    output logic [3:0]  scan_out,
    output logic [7:0]  seg_out
);

    localparam int unsigned CNT_W     = $clog2(SLOT_LEN);
    localparam int unsigned FC_W      = $clog2(BLINK_FRAMES + 1);
    localparam int unsigned DRIVE_MAX = SLOT_LEN - BLANK_LEN;

    typedef enum logic [1:0] {
        SLOT_GUARD,
        SLOT_DRIVE,
        SLOT_DARK
    } slot_t;

    logic [1:0]       digit;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bright_q;
    logic [15:0]      active_data;
    logic [3:0]       active_dp;
    logic [15:0]      shadow_data;
    logic [3:0]       shadow_dp;
    logic             shadow_full;
    logic [FC_W-1:0]  frame_cnt;
    logic             blink_phase;

    slot_t            slot_state;
    logic             slot_end;
    logic             frame_start;
    logic             frame_end;
    logic             accept;
    logic [31:0]      on_len;
    logic [3:0]       cur_nib;
    logic             suppressed;
    logic             blinked;
    logic [6:0]       glyph;
    logic [3:0]       scan_nxt;
    logic [7:0]       seg_nxt;

    assign upd_ready = ~shadow_full;

    // Phase landmarks and handshake acceptance.
    always_comb begin
        slot_end    = (cnt == CNT_W'(SLOT_LEN - 1));
        frame_start = (digit == 2'd0) && (cnt == '0);
        frame_end   = (digit == 2'd3) && slot_end;
        accept      = upd_valid && ~shadow_full;
    end

    // Slot sub-state from the registered counter; DRIVE length clamps to the slot.
    always_comb begin
        on_len = (32'(bright_q) < DRIVE_MAX) ? 32'(bright_q) : DRIVE_MAX;
        if (32'(cnt) < BLANK_LEN)
            slot_state = SLOT_GUARD;
        else if (32'(cnt) < BLANK_LEN + on_len)
            slot_state = SLOT_DRIVE;
        else
            slot_state = SLOT_DARK;
    end

    // Current digit content, suppression/blink qualifiers and hex glyph (gfedcba, active-low).
    always_comb begin
        cur_nib    = 4'h0;
        suppressed = 1'b0;
        case (digit)
            2'd0: begin cur_nib = active_data[15:12]; suppressed = (active_data[15:12] == '0); end
            2'd1: begin cur_nib = active_data[11:8];  suppressed = (active_data[15:8]  == '0); end
            2'd2: begin cur_nib = active_data[7:4];   suppressed = (active_data[15:4]  == '0); end
            default: begin cur_nib = active_data[3:0]; suppressed = 1'b0; end
        endcase
        suppressed = suppressed && lzs_en;
        blinked    = blink_mask[digit] && blink_phase;
        case (cur_nib)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    end

    // Next pin values: only an unblanked DRIVE cycle pulls anything low.
    always_comb begin
        scan_nxt = '1;
        seg_nxt  = '1;
        if (slot_state == SLOT_DRIVE && !suppressed && !blinked) begin
            scan_nxt = ~(4'b0001 << digit);
            seg_nxt  = {~active_dp[digit], glyph};
        end
    end

    // Scan phase: cnt within the slot, digit across the frame.
    always_ff @(posedge base_scan_clock or posedge RESETn) begin
        if (RESETn) begin
            cnt   <= '0;
            digit <= 2'd0;
        end else if (slot_end) begin
            cnt   <= '0;
            digit <= digit + 2'd1;
        end else begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // Brightness latched once per frame; blink phase toggles every BLINK_FRAMES frames.
    always_ff @(posedge base_scan_clock or posedge RESETn) begin
        if (RESETn) begin
            bright_q    <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (frame_start)
                bright_q <= brightness;
            if (frame_end) begin
                if (32'(frame_cnt) == BLINK_FRAMES - 1) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt   <= frame_cnt + FC_W'(1);
                end
            end
        end
    end

    // Double buffer: accept into shadow, promote to active only at a frame boundary.
    // Accept and promote never coincide since accept needs an empty shadow.
    always_ff @(posedge base_scan_clock or posedge RESETn) begin
        if (RESETn) begin
            shadow_data <= '0;
            shadow_dp   <= '0;
            shadow_full <= 1'b0;
            active_data <= '0;
            active_dp   <= '0;
        end else if (frame_end && shadow_full) begin
            active_data <= shadow_data;
            active_dp   <= shadow_dp;
            shadow_full <= 1'b0;
        end else if (accept) begin
            shadow_data <= upd_data;
            shadow_dp   <= upd_dp;
            shadow_full <= 1'b1;
        end
    end

    // Registered pins: one cycle behind the phase, glitch-free.
    always_ff @(posedge base_scan_clock or posedge RESETn) begin
        if (RESETn) begin
            scan_out <= '1;
            seg_out  <= '1;
        end else begin
            scan_out <= scan_nxt;
            seg_out  <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// Scoreboard bench for seven_seg_display_ctrl: the stimulus process runs a
// frame-arithmetic reference model and queues the expected pins for every
// edge; a monitor pops one entry per cycle and compares.
module tb_seven_seg_display_ctrl;

    localparam int SL    = 16;
    localparam int BL    = 1;
    localparam int BF    = 2;
    localparam int FRAME = 4 * SL;

    logic        clk;
    logic        RESETn;
    logic        upd_valid;
    logic        upd_ready;
    logic [15:0] upd_data;
    logic [3:0]  upd_dp;
    logic [3:0]  brightness;
    logic        lzs_en;
    logic [3:0]  blink_mask;
    logic [3:0]  scan_out;
    logic [7:0]  seg_out;

    seven_seg_display_ctrl #(
        .SLOT_LEN(SL),
        .BLANK_LEN(BL),
        .BLINK_FRAMES(BF)
    ) dut (
        .base_scan_clock(clk),
        .RESETn(RESETn),
        .upd_valid(upd_valid),
        .upd_ready(upd_ready),
        .upd_data(upd_data),
        .upd_dp(upd_dp),
        .brightness(brightness),
        .lzs_en(lzs_en),
        .blink_mask(blink_mask),
        .scan_out(scan_out),
        .seg_out(seg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] scan;
        logic [7:0] seg;
        logic       ready;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Standard common-anode hex glyphs {dp,g..a}, dp off.
    logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model state.
    int          m_n;
    int          m_bright;
    logic [15:0] m_active;
    logic [3:0]  m_dp;
    logic        m_full;
    logic [15:0] m_sh;
    logic [3:0]  m_shdp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected pins after the coming edge, from frame position arithmetic.
    task automatic model_step();
        exp_t        e;
        int          pos, f, d, c, lit_end;
        logic [15:0] lead, sh;
        logic        bnd, acc, lit;
        e.scan = 4'hF;
        e.seg  = 8'hFF;
        if (RESETn) begin
            m_n = 0; m_bright = 0; m_active = '0; m_dp = '0; m_full = 1'b0;
        end else begin
            pos = m_n % FRAME;
            f   = m_n / FRAME;
            d   = pos / SL;
            c   = pos % SL;
            lit_end = BL + ((m_bright < SL - BL) ? m_bright : SL - BL);
            lead = m_active >> (12 - 4 * d);
            lit  = (c >= BL) && (c < lit_end);
            if (lzs_en && d <= 2 && lead == 16'h0) lit = 1'b0;
            if (blink_mask[d] && ((f / BF) % 2 == 1)) lit = 1'b0;
            if (lit) begin
                sh     = m_active >> (4 * (3 - d));
                e.scan = 4'hF ^ (4'h1 << d);
                e.seg  = glyph_tab[sh[3:0]] & (m_dp[d] ? 8'h7F : 8'hFF);
            end
            if (pos == 0) m_bright = int'(brightness);
            bnd = (pos == FRAME - 1) && m_full;
            acc = upd_valid && !m_full;
            if (bnd) begin m_active = m_sh; m_dp = m_shdp; m_full = 1'b0; end
            if (acc) begin m_sh = upd_data; m_shdp = upd_dp; m_full = 1'b1; end
            m_n++;
        end
        e.ready = !m_full;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] dp);
        int k = 0;
        upd_valid = 1'b1;
        upd_data  = d;
        upd_dp    = dp;
        while (!m_full && !(k == 0 && m_full) && k < 0) k++;
        while (m_full && k < 4 * FRAME) begin
            tick();
            k++;
        end
        tick();
        upd_valid = 1'b0;
    endtask

    // Monitor: one expected entry per edge, sampled away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("scan_out", 32'(scan_out), 32'(e.scan));
                chk("seg_out", 32'(seg_out), 32'(e.seg));
                chk("upd_ready", 32'(upd_ready), 32'(e.ready));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int k;
        RESETn = 1'b1; upd_valid = 1'b0; upd_data = '0; upd_dp = '0;
        brightness = '0; lzs_en = 1'b0; blink_mask = '0;
        repeat (3) tick();
        chk("reset_scan", 32'(scan_out), 32'h0000000F);
        chk("reset_seg", 32'(seg_out), 32'h000000FF);
        chk("reset_ready", 32'(upd_ready), 32'h1);
        RESETn = 1'b0;
        repeat (FRAME + 4) tick();

        // Scan sequence with dp on digit 2.
        brightness = 4'd15;
        load(16'h1234, 4'b0100);
        repeat (3 * FRAME) tick();

        // PWM, including mid-frame brightness changes.
        brightness = 4'd4;
        repeat (FRAME + FRAME / 2) tick();
        brightness = 4'd9;
        repeat (FRAME) tick();
        brightness = 4'd4;
        repeat (FRAME) tick();

        // Handshake: second offer held while the first waits in the shadow.
        upd_valid = 1'b1; upd_data = 16'h0001; upd_dp = 4'b0000;
        tick();
        upd_data = 16'h0002;
        repeat (3 * FRAME) tick();
        upd_valid = 1'b0;
        repeat (FRAME) tick();

        // Accept landing exactly in the boundary cycle.
        k = 0;
        while (!(!m_full && (m_n % FRAME) == FRAME - 1) && k < 4 * FRAME) begin
            tick();
            k++;
        end
        upd_valid = 1'b1; upd_data = 16'hABCD; upd_dp = 4'b1001;
        tick();
        upd_valid = 1'b0;
        repeat (2 * FRAME + 4) tick();

        // Leading-zero suppression.
        brightness = 4'd15;
        lzs_en = 1'b1;
        load(16'h0070, 4'b0000);
        repeat (2 * FRAME) tick();
        load(16'h0000, 4'b0000);
        repeat (2 * FRAME) tick();

        // Blink on digit 3 only.
        lzs_en = 1'b0;
        blink_mask = 4'b1000;
        load(16'h8888, 4'b0000);
        repeat (6 * FRAME) tick();

        // Randomized traffic.
        for (int i = 0; i < 30 * FRAME; i++) begin
            upd_valid = ($urandom % 4) == 0;
            k = $urandom_range(0, 4);
            upd_data = 16'($urandom) >> (4 * k);
            upd_dp = 4'($urandom);
            if ($urandom % 40 == 0) brightness = 4'($urandom);
            if ($urandom % 50 == 0) lzs_en = 1'($urandom);
            if ($urandom % 60 == 0) blink_mask = 4'($urandom);
            tick();
        end
        upd_valid = 1'b0;

        // Asynchronous reset in the middle of a DRIVE cycle.
        brightness = 4'd15; lzs_en = 1'b0; blink_mask = 4'b0000;
        load(16'h1234, 4'b0000);
        repeat (2 * FRAME) tick();
        k = 0;
        while ((m_n % FRAME) != 20 && k < 2 * FRAME) begin
            tick();
            k++;
        end
        upd_valid = 1'b1; upd_data = 16'h5555;
        tick();
        upd_valid = 1'b0;
        #3;
        RESETn = 1'b1;
        #1;
        chk("async_reset_scan", 32'(scan_out), 32'h0000000F);
        chk("async_reset_seg", 32'(seg_out), 32'h000000FF);
        chk("async_reset_ready", 32'(upd_ready), 32'h1);
        repeat (2) tick();
        RESETn = 1'b0;
        brightness = 4'd0;
        repeat (FRAME + 4) tick();
        brightness = 4'd15;
        repeat (FRAME + 4) tick();

        @(posedge clk);
        #5;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
